// File: rtl/imm_encoder.sv
// imm_encoder: packs RISC-V I/S/B instruction words from separate fields.
// Two-stage valid/ready pipeline. S1 captures the fields and the immediate
// range check. S2 holds the packed word and the error flag until the
// downstream side accepts it.
module imm_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic [15:0] enc_cnt_o,
  output logic [7:0]  err_cnt_o
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [1:0]  FMT_I     = 2'd0;
  localparam logic [1:0]  FMT_S     = 2'd1;
  localparam logic [1:0]  FMT_B     = 2'd2;

  // Stage 1 state. Only imm[12:0] is kept because the range check has
  // already consumed the upper bits.
  logic        s1_valid_q,  s1_valid_d;
  logic [1:0]  s1_fmt_q,    s1_fmt_d;
  logic [6:0]  s1_opcode_q, s1_opcode_d;
  logic [2:0]  s1_funct3_q, s1_funct3_d;
  logic [4:0]  s1_rd_q,     s1_rd_d;
  logic [4:0]  s1_rs1_q,    s1_rs1_d;
  logic [4:0]  s1_rs2_q,    s1_rs2_d;
  logic [12:0] s1_imm_q,    s1_imm_d;
  logic        s1_err_q,    s1_err_d;

  // Stage 2 state and counters.
  logic        s2_valid_q,  s2_valid_d;
  logic [31:0] s2_instr_q,  s2_instr_d;
  logic        s2_err_q,    s2_err_d;
  logic [15:0] enc_cnt_q,   enc_cnt_d;
  logic [7:0]  err_cnt_q,   err_cnt_d;

  logic        out_xfer;
  logic        s2_free;
  logic        s1_adv;
  logic        in_xfer;
  logic        fits12;
  logic        fits13;
  logic        in_err;
  logic [31:0] pack_instr;

  // Handshake: S2 can take a new beat when it is empty or draining this cycle.
  always_comb begin
    out_xfer = s2_valid_q & ready_i;
    s2_free  = ~s2_valid_q | ready_i;
    s1_adv   = s1_valid_q & s2_free;
    ready_o  = (~s1_valid_q | s2_free) & rst_i;
    in_xfer  = valid_i & ready_o;
  end

  // Range check on the incoming immediate: the upper bits must be a sign extension.
  always_comb begin
    fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    case (fmt_i)
      FMT_I, FMT_S: in_err = ~fits12;
      FMT_B:        in_err = ~fits13 | imm_i[0];
      default:      in_err = 1'b1;
    endcase
  end

  // S1 next state: load on an input transfer, hold while S2 is blocked.
  always_comb begin
    s1_valid_d  = in_xfer | (s1_valid_q & ~s2_free);
    s1_fmt_d    = s1_fmt_q;
    s1_opcode_d = s1_opcode_q;
    s1_funct3_d = s1_funct3_q;
    s1_rd_d     = s1_rd_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_imm_d    = s1_imm_q;
    s1_err_d    = s1_err_q;
    if (in_xfer) begin
      s1_fmt_d    = fmt_i;
      s1_opcode_d = opcode_i;
      s1_funct3_d = funct3_i;
      s1_rd_d     = rd_i;
      s1_rs1_d    = rs1_i;
      s1_rs2_d    = rs2_i;
      s1_imm_d    = imm_i[12:0];
      s1_err_d    = in_err;
    end
  end

  // Instruction packing from the S1 fields; an error beat becomes a NOP.
  always_comb begin
    case (s1_fmt_q)
      FMT_I:   pack_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FMT_S:   pack_instr = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                             s1_imm_q[4:0], s1_opcode_q};
      FMT_B:   pack_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                             s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
      default: pack_instr = NOP_INSTR;
    endcase
    if (s1_err_q) begin
      pack_instr = NOP_INSTR;
    end
  end

  // S2 next state and delivery counters.
  always_comb begin
    s2_valid_d = s1_adv | (s2_valid_q & ~ready_i);
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s1_adv) begin
      s2_instr_d = pack_instr;
      s2_err_d   = s1_err_q;
    end
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (out_xfer && !s2_err_q) begin
      enc_cnt_d = enc_cnt_q + 16'd1;
    end
    if (out_xfer && s2_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= 2'd0;
      s1_opcode_q <= 7'd0;
      s1_funct3_q <= 3'd0;
      s1_rd_q     <= 5'd0;
      s1_rs1_q    <= 5'd0;
      s1_rs2_q    <= 5'd0;
      s1_imm_q    <= 13'd0;
      s1_err_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= 32'd0;
      s2_err_q    <= 1'b0;
      enc_cnt_q   <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_opcode_q <= s1_opcode_d;
      s1_funct3_q <= s1_funct3_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_imm_q    <= s1_imm_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      enc_cnt_q   <= enc_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign valid_o   = s2_valid_q;
  assign instr_o   = s2_instr_q;
  assign err_o     = s2_err_q;
  assign enc_cnt_o = enc_cnt_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  synchronous active-low reset.
REQ-004 valid_i  input  1  input beat valid.
REQ-005 ready_o  output  1  block can accept an input beat.
REQ-006 fmt_i  input  2  format: 0=I, 1=S, 2=B, 3=reserved.
REQ-007 opcode_i  input  7  opcode field.
REQ-008 funct3_i  input  3  funct3 field.
REQ-009 rd_i, rs1_i, rs2_i  input  5 each  register fields.
REQ-010 imm_i  input  32  signed immediate, as a byte offset for B.
REQ-011 valid_o  output  1  output beat valid.
REQ-012 ready_i  input  1  downstream accepts the output beat.
REQ-013 instr_o  output  32  encoded instruction word.
REQ-014 err_o  output  1  the current output beat was rejected.
REQ-015 enc_cnt_o  output  16  count of good beats delivered.
REQ-016 err_cnt_o  output  8  count of error beats delivered.

Function
REQ-017 A transfer SHALL occur on a cycle with valid && ready, on both the input and output sides.
REQ-018 The datapath SHALL be a 2-stage pipeline:
- S1 registers the fields and the range-check result.
- S2 registers instr_o and err_o.
REQ-019 Latency SHALL be 2 cycles from the input transfer to valid_o, with no stall.
REQ-020 Throughput SHALL be one beat per cycle when ready_i=1.
REQ-021 S1 SHALL advance when S2 is empty or S2 is transferring that cycle.
REQ-022 ready_o SHALL equal (S1 empty or S1 advancing) and rst_i=1; it is combinational on ready_i.
REQ-023 While valid_o=1 and ready_i=0, instr_o and err_o SHALL hold stable, and valid_o SHALL NOT drop.
REQ-024 Beats SHALL leave the block in acceptance order; no beat is dropped or duplicated.
REQ-025 I packing SHALL be {imm[11:0], rs1, funct3, rd, opcode}.
REQ-026 S packing SHALL be {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; rd_i is ignored.
REQ-027 B packing SHALL be {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; rd_i is ignored.
REQ-028 Range check for I and S: imm_i[31:11] SHALL be all-equal, otherwise error.
REQ-029 Range check for B: imm_i[31:12] SHALL be all-equal and imm_i[0]=0, otherwise error.
REQ-030 fmt_i=3 SHALL always be an error.
REQ-031 On an error beat, instr_o SHALL be 0x00000013 (NOP) and err_o=1.
- The beat is still delivered through the handshake.
- err_o=0 on all good beats.
REQ-032 enc_cnt_o SHALL increment on each output transfer with err_o=0 and wrap 0xFFFF to 0x0000.
REQ-033 err_cnt_o SHALL increment on each output transfer with err_o=1 and saturate at 0xFF.
REQ-034 A simultaneous input transfer, output transfer and S1-to-S2 advance in one cycle SHALL lose no data.

Reset
REQ-035 With rst_i=0 at a clock edge, the block SHALL clear:
- both stage valid bits;
- valid_o=0, err_o=0, instr_o=0x00000000;
- enc_cnt_o=0, err_cnt_o=0.
REQ-036 ready_o SHALL be 0 while rst_i=0 and 1 in the first cycle after release.
REQ-037 A reset asserted mid-operation SHALL discard all in-flight beats without delivering them.
REQ-038 The counters SHALL NOT count beats discarded by reset.

Verification
REQ-039 I beat (opcode 0x13, funct3 0, rd 1, rs1 2, imm 0xFFFFFFFF), ready_i=1 -> 2 cycles later instr_o=0xFFF10093, err_o=0, enc_cnt_o=1.
REQ-040 S beat (opcode 0x23, funct3 2, rs1 2, rs2 5, imm 8) -> instr_o=0x00512423; then B beat (opcode 0x63, funct3 0, rs1 1, rs2 2, imm 0xFFFFFFFC) -> instr_o=0xFE208EE3.
REQ-041 I beat with imm 2048, then B beat with imm 3, then fmt 3 -> three beats with err_o=1 and instr_o=0x00000013; err_cnt_o=3, enc_cnt_o unchanged.
REQ-042 ready_i=0 with 4 back-to-back valid inputs:
- ready_o drops after 2 accepts and instr_o stays stable;
- releasing ready_i delivers all beats in order, one per cycle.
REQ-043 rst_i=0 for 1 cycle with both stages full -> valid_o=0 and counters 0 next cycle; no stale beat is delivered afterwards.
REQ-044 Preload enc_cnt_o to 0xFFFF with 65535 good beats, then 1 more good beat -> enc_cnt_o=0x0000; 256 error beats -> err_cnt_o holds 0xFF.
